// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared constants, FSM states and helpers for the BCD display
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Largest value representable in 'digits' decimal digits: 10^digits - 1.
   function automatic logic [63:0] max_bcd_value(input int digits);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < digits; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/credit_bcd_display_if.sv
// ============================================================================
// credit_bcd_display_if : count-in / digits-out bundle of the BCD display
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

interface credit_bcd_display_if #(
   parameter int CNT_W  = 4,
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [CNT_W-1:0]      count;
   logic                  blank_lz;
   logic [4*DIGITS-1:0]   digits;
   logic                  out_valid;
   logic                  ovf;

   modport master (
      output in_valid, count, blank_lz,
      input  in_ready, digits, out_valid, ovf
   );

   modport slave (
      input  in_valid, count, blank_lz,
      output in_ready, digits, out_valid, ovf
   );
endinterface

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// bcd_digit_adj : double-dabble digit correction (>=5 -> +3), combinational
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
   input  wire logic [3:0] d_i,
   output logic      [3:0] d_o
);
   assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

`default_nettype wire

// File: rtl/credit_bcd_display.sv
// ============================================================================
// credit_bcd_display : scales a credit count by STEP and converts it to BCD
//                      digits via a shift-and-add-3 FSM, with saturation
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_bcd_display
   import display_pkg::*;
#(
   parameter int CNT_W  = 4,
   parameter int STEP   = 10,
   parameter int DIGITS = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   credit_bcd_display_if.slave   bus
);

   localparam int          PROD_W   = (STEP == 1) ? CNT_W : CNT_W + $clog2(STEP);
   localparam int          BCD_W    = 4 * DIGITS;
   localparam int          CNT_BITS = $clog2(PROD_W + 1);
   localparam logic [63:0] MAX_VAL  = max_bcd_value(DIGITS);

   state_t                state_q,     state_d;
   logic [PROD_W-1:0]     bin_q,       bin_d;
   logic [BCD_W-1:0]      bcd_q,       bcd_d;
   logic [CNT_BITS-1:0]   cnt_q,       cnt_d;
   logic                  ovf_pend_q,  ovf_pend_d;
   logic                  blank_q,     blank_d;
   logic [BCD_W-1:0]      digits_q,    digits_d;
   logic                  ovf_q,       ovf_d;
   logic                  out_valid_q, out_valid_d;

   logic [PROD_W-1:0]     w_prod;
   logic                  w_prod_ovf;
   logic [BCD_W-1:0]      w_bcd_adj;
   logic [BCD_W-1:0]      w_blanked;

   assign w_prod     = PROD_W'(bus.count) * PROD_W'(STEP);
   assign w_prod_ovf = (64'(w_prod) > MAX_VAL);

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i (bcd_q[4*gi +: 4]),
         .d_o (w_bcd_adj[4*gi +: 4])
      );
   end

   // Blank every digit above the most significant non-zero one; digit 0 always shows.
   always_comb begin
      logic w_seen;
      w_seen    = 1'b0;
      w_blanked = bcd_q;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            w_seen = 1'b1;
         end
         if (!w_seen) begin
            w_blanked[4*i +: 4] = BLANK_CODE;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      ovf_pend_d  = ovf_pend_q;
      blank_d     = blank_q;
      digits_d    = digits_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bin_d      = w_prod;
               bcd_d      = '0;
               cnt_d      = CNT_BITS'(PROD_W);
               ovf_pend_d = w_prod_ovf;
               blank_d    = bus.blank_lz;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {w_bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q - CNT_BITS'(1);
            if (cnt_q == CNT_BITS'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (ovf_pend_q) begin
               digits_d = {DIGITS{4'h9}};
            end else if (blank_q) begin
               digits_d = w_blanked;
            end else begin
               digits_d = bcd_q;
            end
            ovf_d       = ovf_pend_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         ovf_pend_q  <= 1'b0;
         blank_q     <= 1'b0;
         digits_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         ovf_pend_q  <= ovf_pend_d;
         blank_q     <= blank_d;
         digits_q    <= digits_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.digits    = digits_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_credit_bcd_display.sv
// ============================================================================
// tb_credit_bcd_display : scoreboard bench over four parameter variants
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_credit_bcd_display;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [3:0]        vld, blk, rdy, ovv, ovf;
   logic [3:0][3:0]   cnt;
   logic [3:0][31:0]  dig;
   int                checks   = 0;
   int                failures = 0;
   int                cyc      = 0;
   int                gap     [4];
   int                pending [4];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int step_of(int g);
      case (g)
         0: return 10;
         1: return 10;
         2: return 1;
         default: return 25;
      endcase
   endfunction

   function automatic int digits_of(int g);
      case (g)
         0: return 4;
         1: return 2;
         2: return 1;
         default: return 2;
      endcase
   endfunction

   function automatic int pw_of(int g);
      return 4 + $clog2(step_of(g));
   endfunction

   // Decimal reference: {ovf, digits}, built from plain division and powers of ten.
   function automatic logic [32:0] model(int c, int st, int dg, bit b);
      longint      val;
      longint      maxv;
      longint      p;
      logic [31:0] d;
      val  = longint'(c) * longint'(st);
      maxv = 1;
      d    = '0;
      for (int i = 0; i < dg; i++) maxv = maxv * 10;
      maxv = maxv - 1;
      if (val > maxv) begin
         for (int i = 0; i < dg; i++) d[4*i +: 4] = 4'h9;
         return {1'b1, d};
      end
      p = 1;
      for (int i = 0; i < dg; i++) begin
         if (b && i > 0 && val < p) d[4*i +: 4] = 4'hF;
         else                       d[4*i +: 4] = 4'((val / p) % 10);
         p = p * 10;
      end
      return {1'b0, d};
   endfunction

   task automatic check(string name, int dut, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", name, dut, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int ST = step_of(g);
      localparam int DG = digits_of(g);
      localparam int PW = pw_of(g);

      credit_bcd_display_if #(.CNT_W(4), .DIGITS(DG)) bus ();

      assign bus.in_valid = vld[g];
      assign bus.count    = cnt[g];
      assign bus.blank_lz = blk[g];
      assign rdy[g]       = bus.in_ready;
      assign ovv[g]       = bus.out_valid;
      assign ovf[g]       = bus.ovf;
      assign dig[g]       = 32'(bus.digits);

      credit_bcd_display #(.CNT_W(4), .STEP(ST), .DIGITS(DG)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      logic [32:0] exp_q [$];
      int          acc_q [$];
      int          last_ov = -1;
      logic [32:0] e;
      int          a;

      always @(negedge clk) begin
         if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            last_ov = -1;
         end else begin
            if (ovv[g]) begin
               if (exp_q.size() == 0) begin
                  check("out_valid_without_accept", g, 32'(ovv[g]), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  a = acc_q.pop_front();
                  check("digits", g, dig[g], e[31:0]);
                  check("ovf", g, 32'(ovf[g]), 32'(e[32]));
                  check("latency", g, 32'(cyc - a), 32'(PW + 2));
               end
               if (last_ov >= 0) gap[g] = cyc - last_ov;
               last_ov = cyc;
            end
            if (vld[g] && rdy[g]) begin
               exp_q.push_back(model(int'(cnt[g]), ST, DG, blk[g]));
               acc_q.push_back(cyc);
            end
         end
         pending[g] = exp_q.size();
      end
   end

   // Callers sit just after a rising edge; returns just after the accepting edge.
   task automatic send(int k, int c, bit b);
      int n;
      n = 0;
      vld[k] = 1'b1;
      cnt[k] = 4'(c);
      blk[k] = b;
      @(negedge clk);
      while (!rdy[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", k, 32'(rdy[k]), 32'd1);
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
      cnt[k] = 4'($urandom);
      blk[k] = 1'($urandom);
   endtask

   task automatic wait_idle(int k);
      int n;
      n = 0;
      while (pending[k] != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("drain", k, 32'(pending[k]), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(int r);
      repeat (r) @(posedge clk);
      #1;
   endtask

   task automatic sweep(int k);
      for (int c = 0; c < 16; c++) begin
         send(k, c, 1'($urandom));
         idle_gap(int'($urandom_range(0, 3)));
      end
      for (int j = 0; j < 10; j++) begin
         send(k, int'($urandom_range(0, 15)), 1'($urandom));
         idle_gap(int'($urandom_range(0, 2)));
      end
      wait_idle(k);
   endtask

   initial begin
      vld   = '0;
      blk   = '0;
      cnt   = '0;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gap[i]     = 0;
         pending[i] = 0;
      end

      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("reset_in_ready", k, 32'(rdy[k]), 32'd1);
         check("reset_digits", k, dig[k], 32'd0);
         check("reset_ovf", k, 32'(ovf[k]), 32'd0);
         check("reset_out_valid", k, 32'(ovv[k]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_gap(1);

      send(0, 0, 1'b0);
      send(0, 10, 1'b1);
      send(0, 7, 1'b0);
      wait_idle(0);

      send(1, 15, 1'b0);
      send(1, 9, 1'b0);
      wait_idle(1);

      send(0, 3, 1'b0);
      send(0, 4, 1'b0);
      wait_idle(0);
      check("b2b_gap", 0, 32'(gap[0]), 32'(pw_of(0) + 2));

      fork
         sweep(0);
         sweep(1);
         sweep(2);
         sweep(3);
      join

      // Abort a conversion mid-shift; nothing may come out of it.
      send(0, 9, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 0, 32'(rdy[0]), 32'd1);
      check("abort_digits", 0, dig[0], 32'd0);
      check("abort_ovf", 0, 32'(ovf[0]), 32'd0);
      check("abort_out_valid", 0, 32'(ovv[0]), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_gap(pw_of(0) + 4);
      check("post_abort_digits", 0, dig[0], 32'd0);
      send(0, 2, 1'b0);
      wait_idle(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/credit_bcd_display.md
# credit_bcd_display

Sequential, parametrised successor to the fixed count-to-digit decoder in the display path. Accepts a coin/credit count over a valid/ready handshake, scales it by a constant step, converts the product to BCD with a shift-and-add-3 (double-dabble) state machine, and holds the resulting digits for the seven-segment multiplexer. It adds a configurable digit count, configurable step value, overflow saturation and optional leading-zero blanking.

## Interface
- CNT_W, 4: width of the incoming count.
- STEP, 10: constant multiplier applied to the count, ≥1.
- DIGITS, 4: number of BCD output digits, 1..8.
- PROD_W (localparam): CNT_W + $clog2(STEP), or CNT_W when STEP==1; binary product width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  count presented.
- in_ready  out  1  block idle and able to accept.
- count  in  CNT_W  credit count, sampled on accept.
- blank_lz  in  1  leading-zero blanking mode, sampled on accept.
- digits  out  4*DIGITS  digit i at [4i+3:4i]; digit 0 = ones.
- out_valid  out  1  one-cycle pulse when digits update.
- ovf  out  1  last result exceeded 10^DIGITS−1; held with digits.

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE), combinational from state.
- Accept: in_valid && in_ready at a rising edge. Register bin = count*STEP (PROD_W bits), bcd = 0, bit counter = PROD_W, ovf_pend = (bin > 10^DIGITS−1), blank mode latched; go to SHIFT.
- SHIFT, each cycle: for every digit ≥5 add 3, then shift {bcd,bin} left by 1. Decrement bit counter; after the PROD_W-th shift go to DONE.
- DONE, one cycle: load the digits register, set ovf = ovf_pend, pulse out_valid, return to IDLE.
- Overflow: digits = all 9s (for example 0x99 for DIGITS=2), ovf=1. Blanking is not applied.
- Blanking (non-overflow, blank_lz latched 1): each digit above the most significant non-zero digit = 4'hF. Digit 0 is never blanked, so a value of 0 shows as 0.
- in_valid while busy is ignored (in_ready=0). Inputs that change after accept have no effect on the conversion in progress.
- digits and ovf hold their value until the next DONE.

## Timing
- Reset (async assert): state=IDLE, digits=0, ovf=0, out_valid=0, internal regs 0, so in_ready=1 while rst_n is low and after release.
- Reset during SHIFT/DONE aborts the conversion. No out_valid is produced and the outputs return to 0.
- Latency: accept at edge N gives out_valid high and new digits in the cycle after edge N+PROD_W+1. For defaults (PROD_W=8) that is 9 cycles.
- Throughput: one conversion per PROD_W+2 cycles. in_ready rises in the cycle after the out_valid edge.
- out_valid is registered and exactly one cycle wide.

## Structure
- Shared package display_pkg holds:
  - BLANK_CODE = 4'hF
  - the state enum {IDLE, SHIFT, DONE}
  - a function for 10^DIGITS−1
- Sub-module bcd_digit_adj: combinational 4-bit "≥5 → +3" correction, instantiated DIGITS times by generate.
- Target is about 150–250 lines of RTL.

## Test plan
- Reset then count=0, blank_lz=0 (defaults) -> digits=16'h0000, ovf=0, out_valid 9 cycles after accept.
- count=10, blank_lz=1 -> digits=16'hF100 (100 with the leading digit blanked), ovf=0. Then count=7, blank_lz=0 -> 16'h0070.
- DIGITS=2, count=15 -> product 150 > 99 -> digits=8'h99, ovf=1. A following count=9 -> 8'h90, ovf=0.
- Back-to-back in_valid held high with count=3, then 4 -> second accept only when in_ready returns. Results 0x0030 then 0x0040. out_valid pulses are exactly PROD_W+2 cycles apart.
- Deassert rst_n at SHIFT cycle 4 of count=9 -> no out_valid, digits=0, in_ready=1 while in reset. After release, count=2 -> 0x0020.
- Exhaustive sweep of count 0..15 with STEP ∈ {1, 10, 25} -> digits match a decimal reference model, and ovf asserts only when the product exceeds 10^DIGITS−1.
